// File: rtl/vga_pkg.sv
// Shared VGA definitions for the pattern generator and the sync decoder.
// Holds the 640x480 frame geometry, the lock state encoding and a small
// wrap-around counter helper.
package vga_pkg;

    localparam int unsigned VGA_VIDEO_WIDTH   = 3;
    localparam int unsigned VGA_TOTAL_COLS    = 800;
    localparam int unsigned VGA_TOTAL_ROWS    = 525;
    localparam int unsigned VGA_ACTIVE_COLS   = 640;
    localparam int unsigned VGA_ACTIVE_ROWS   = 480;
    localparam int unsigned VGA_H_FRONT_PORCH = 18;
    localparam int unsigned VGA_V_FRONT_PORCH = 10;
    localparam int unsigned VGA_H_SYNC_START  = VGA_ACTIVE_COLS + VGA_H_FRONT_PORCH;
    localparam int unsigned VGA_V_SYNC_START  = VGA_ACTIVE_ROWS + VGA_V_FRONT_PORCH;
    localparam int unsigned VGA_LOCK_FRAMES   = 2;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } lock_state_t;

    // Next value of a counter that wraps from 'last' back to zero.
    function automatic logic [9:0] wrap_inc(input logic [9:0] value, input logic [9:0] last);
        return (value == last) ? '0 : value + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Two-stage input register for one active-low sync line plus falling-edge
// detect. Both stages reset to 1 (idle) so reset release never fakes an edge.
// Ports:
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   sync  - raw sync input from the pin
//   fall  - high while the newer stage holds the first low sample
module vga_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= sync;
            s2 <= s1;
        end
    end

    assign fall = ~s1 & s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive front end: recovers pixel column/row from HSync/VSync, checks
// sync timing against the expected geometry, and runs a SEARCH/TRACK/LOCKED
// lock machine.
// Ports:
//   i_Clk, i_Rst_L                     - pixel clock, async active-low reset
//   i_HSync, i_VSync                   - active-low syncs
//   i_Red/Grn/Blu_Video                - pixel data in
//   o_Col_Count, o_Row_Count           - coordinates of the pixel on o_*_Video
//   o_Red/Grn/Blu_Video                - pixel data, zero outside active video
//   o_Active, o_Frame_Start, o_Locked  - qualifiers (all low while unlocked)
//   o_Sync_Err, o_Err_Count            - mismatch pulse while locked, saturating count
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int unsigned c_VIDEO_WIDTH  = VGA_VIDEO_WIDTH,
    parameter int unsigned c_TOTAL_COLS   = VGA_TOTAL_COLS,
    parameter int unsigned c_TOTAL_ROWS   = VGA_TOTAL_ROWS,
    parameter int unsigned c_ACTIVE_COLS  = VGA_ACTIVE_COLS,
    parameter int unsigned c_ACTIVE_ROWS  = VGA_ACTIVE_ROWS,
    parameter int unsigned c_H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned c_V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned c_LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_HSync,
    input  logic                     i_VSync,
    input  logic [c_VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [c_VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [c_VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [9:0]               o_Col_Count,
    output logic [9:0]               o_Row_Count,
    output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                     o_Active,
    output logic                     o_Frame_Start,
    output logic                     o_Locked,
    output logic                     o_Sync_Err,
    output logic [7:0]               o_Err_Count
);

    localparam int unsigned W      = c_VIDEO_WIDTH;
    localparam int unsigned TMO_W  = $clog2(2 * c_TOTAL_COLS);
    localparam int unsigned GOOD_W = $clog2(c_LOCK_FRAMES + 1);

    localparam logic [9:0]        LAST_COL  = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0]        LAST_ROW  = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0]        ACT_COLS  = 10'(c_ACTIVE_COLS);
    localparam logic [9:0]        ACT_ROWS  = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0]        H_SS      = 10'(c_H_SYNC_START);
    localparam logic [9:0]        V_SS      = 10'(c_V_SYNC_START);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(2 * c_TOTAL_COLS - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(c_LOCK_FRAMES - 1);

    logic              h_edge;
    logic              v_edge;
    logic [3*W-1:0]    rgb_s1;
    logic [3*W-1:0]    rgb_s2;
    logic [9:0]        col_q;
    logic [9:0]        row_q;
    logic [9:0]        col_d;
    logic [9:0]        row_d;
    logic [9:0]        pred_col;
    logic [9:0]        pred_row;
    logic [TMO_W-1:0]  h_timer;
    logic [TMO_W-1:0]  h_timer_d;
    logic              timeout;
    logic              mismatch;
    lock_state_t       state;
    lock_state_t       state_d;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_d;
    logic              h_seen;
    logic [7:0]        err_q;
    logic [7:0]        err_d;
    logic              sync_err_q;
    logic              sync_err_d;

    vga_edge_sync u_hsync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .sync  (i_HSync),
        .fall  (h_edge)
    );

    vga_edge_sync u_vsync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .sync  (i_VSync),
        .fall  (v_edge)
    );

    // Edges are judged on the newer sync stage; the counters registered on
    // that cycle then line up with the older stage, which is where the RGB
    // output is taken from.
    always_comb begin
        pred_col = wrap_inc(col_q, LAST_COL);
        pred_row = (col_q == LAST_COL) ? wrap_inc(row_q, LAST_ROW) : row_q;

        col_d = pred_col;
        row_d = pred_row;
        if (v_edge) begin
            col_d = '0;
            row_d = V_SS;
        end else if (h_edge) begin
            col_d = H_SS;
        end

        timeout   = !h_edge && (h_timer == TMO_LAST);
        h_timer_d = (h_edge || timeout) ? '0 : h_timer + 1'b1;

        mismatch = (h_edge && (pred_col != H_SS))
                || (v_edge && ((pred_col != '0) || (pred_row != V_SS)))
                || timeout;
    end

    always_comb begin
        state_d    = state;
        good_d     = good;
        err_d      = err_q;
        sync_err_d = 1'b0;
        case (state)
            SEARCH: begin
                if (v_edge && h_seen) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (mismatch) begin
                    state_d = SEARCH;
                end else if (v_edge) begin
                    good_d = good + 1'b1;
                    if (good == GOOD_LAST) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rgb_s1     <= '0;
            rgb_s2     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            h_timer    <= '0;
            h_seen     <= 1'b0;
            state      <= SEARCH;
            good       <= '0;
            err_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            rgb_s1     <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
            rgb_s2     <= rgb_s1;
            col_q      <= col_d;
            row_q      <= row_d;
            h_timer    <= h_timer_d;
            h_seen     <= h_seen | h_edge;
            state      <= state_d;
            good       <= good_d;
            err_q      <= err_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign o_Locked      = (state == LOCKED);
    assign o_Active      = o_Locked && (col_q < ACT_COLS) && (row_q < ACT_ROWS);
    assign o_Frame_Start = o_Locked && (col_q == '0) && (row_q == '0);
    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Red_Video   = o_Active ? rgb_s2[3*W-1:2*W] : '0;
    assign o_Grn_Video   = o_Active ? rgb_s2[2*W-1:W]   : '0;
    assign o_Blu_Video   = o_Active ? rgb_s2[W-1:0]     : '0;
    assign o_Sync_Err    = sync_err_q;
    assign o_Err_Count   = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced frame geometry
// (10 cols x 5 rows) so lock, relock and error saturation fit in a short run.
module tb_vga_sync_decoder;

    localparam int TC    = 10;
    localparam int TR    = 5;
    localparam int AC    = 6;
    localparam int AR    = 3;
    localparam int HSS   = 7;
    localparam int VSS   = 4;
    localparam int LOCKF = 2;

    typedef struct {
        int         col;
        int         row;
        logic       hs;
        logic [8:0] rgb;
    } samp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync;
    logic       vsync;
    logic [2:0] red_in;
    logic [2:0] grn_in;
    logic [2:0] blu_in;
    logic [9:0] col_cnt;
    logic [9:0] row_cnt;
    logic [2:0] red_out;
    logic [2:0] grn_out;
    logic [2:0] blu_out;
    logic       active;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_cnt;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    g_col    = 0;
    int    g_row    = 0;
    int    dly_row  = 0;
    bit    dly_on   = 1'b0;
    bit    hold_h   = 1'b0;
    logic  prev_vs  = 1'b1;
    int    v_drops  = 0;
    samp_t cur_s;
    samp_t last_s;
    samp_t exp_s;
    samp_t prev_exp;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .c_VIDEO_WIDTH  (3),
        .c_TOTAL_COLS   (TC),
        .c_TOTAL_ROWS   (TR),
        .c_ACTIVE_COLS  (AC),
        .c_ACTIVE_ROWS  (AR),
        .c_H_SYNC_START (HSS),
        .c_V_SYNC_START (VSS),
        .c_LOCK_FRAMES  (LOCKF)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_HSync       (hsync),
        .i_VSync       (vsync),
        .i_Red_Video   (red_in),
        .i_Grn_Video   (grn_in),
        .i_Blu_Video   (blu_in),
        .o_Col_Count   (col_cnt),
        .o_Row_Count   (row_cnt),
        .o_Red_Video   (red_out),
        .o_Grn_Video   (grn_out),
        .o_Blu_Video   (blu_out),
        .o_Active      (active),
        .o_Frame_Start (frame_start),
        .o_Locked      (locked),
        .o_Sync_Err    (sync_err),
        .o_Err_Count   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one generator sample, clock it in, then age the expectation
    // pipeline: after the edge the DUT shows the sample driven one step earlier.
    task automatic step();
        logic h;
        h = !(g_col >= HSS && g_col < HSS + 2);
        if (dly_on && g_row == dly_row) h = !(g_col >= HSS + 1 && g_col < HSS + 3);
        if (hold_h) h = 1'b1;
        hsync  = h;
        vsync  = (g_row != VSS);
        if (prev_vs && !vsync) v_drops++;
        prev_vs = vsync;
        red_in = 3'($urandom);
        grn_in = 3'($urandom);
        blu_in = 3'($urandom);
        cur_s.col = g_col;
        cur_s.row = g_row;
        cur_s.hs  = h;
        cur_s.rgb = {red_in, grn_in, blu_in};
        @(posedge clk);
        #1;
        prev_exp = exp_s;
        exp_s    = last_s;
        last_s   = cur_s;
        if (g_col == TC - 1) begin
            g_col = 0;
            g_row = (g_row == TR - 1) ? 0 : g_row + 1;
        end else begin
            g_col++;
        end
    endtask

    task automatic check_cycle();
        logic exp_act;
        exp_act = (exp_s.col < AC) && (exp_s.row < AR);
        chk("locked", 32'(locked), 1);
        chk("col", 32'(col_cnt), exp_s.col);
        chk("row", 32'(row_cnt), exp_s.row);
        chk("active", 32'(active), 32'(exp_act));
        chk("frame_start", 32'(frame_start), 32'(exp_s.col == 0 && exp_s.row == 0));
        chk("video", 32'({red_out, grn_out, blu_out}), exp_act ? 32'(exp_s.rgb) : 0);
        chk("sync_err", 32'(sync_err), 0);
        if (!exp_s.hs && prev_exp.hs) chk("hsync_col", 32'(col_cnt), HSS);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_col"}, 32'(col_cnt), 0);
        chk({tag, "_row"}, 32'(row_cnt), 0);
        chk({tag, "_video"}, 32'({red_out, grn_out, blu_out}), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_sync_err"}, 32'(sync_err), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    task automatic wait_lock(input string tag, input int exp_drops, output int pulses);
        int n;
        n       = 0;
        pulses  = 0;
        v_drops = 0;
        while (locked !== 1'b1 && n < 400) begin
            step();
            pulses += int'(sync_err);
            n++;
        end
        chk({tag, "_locked"}, 32'(locked), 1);
        if (exp_drops > 0) chk({tag, "_vdrops"}, v_drops, exp_drops);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;
        int fs_cnt;
        int act_cnt;

        rst_n  = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        red_in = '0;
        grn_in = '0;
        blu_in = '0;
        last_s = '{col: 0, row: 0, hs: 1'b1, rgb: 9'd0};
        exp_s  = last_s;
        prev_exp = last_s;

        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        rst_n = 1'b1;

        // Initial acquisition: lock appears on the second edge after the
        // third VSync fall is sampled.
        v_drops = 0;
        n = 0;
        while (v_drops < 3 && n < 400) begin
            step();
            n++;
        end
        chk("pre_lock", 32'(locked), 0);
        step();
        chk("lock_rise", 32'(locked), 1);

        // Two full locked frames with random pixel data.
        fs_cnt  = 0;
        act_cnt = 0;
        for (int i = 0; i < 2 * TC * TR; i++) begin
            step();
            check_cycle();
            fs_cnt  += int'(frame_start);
            act_cnt += int'(active);
        end
        chk("frame_starts", fs_cnt, 2);
        chk("active_cycles", act_cnt, 2 * AC * AR);

        // One HSync pulse one clock late.
        n = 0;
        while (!(g_row == 1 && g_col == 0) && n < 100) begin
            step();
            n++;
        end
        dly_row = 1;
        dly_on  = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            pulses += int'(sync_err);
        end
        dly_on = 1'b0;
        chk("dly_pulses", pulses, 1);
        chk("dly_err_cnt", 32'(err_cnt), 1);
        chk("dly_unlocked", 32'(locked), 0);
        wait_lock("dly_relock", 3, pulses);

        // HSync stuck high past the timeout.
        hold_h = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            pulses += int'(sync_err);
        end
        hold_h = 1'b0;
        chk("tmo_pulses", pulses, 1);
        chk("tmo_err_cnt", 32'(err_cnt), 2);
        chk("tmo_unlocked", 32'(locked), 0);
        wait_lock("tmo_relock", 3, pulses);

        // Reset mid-line while locked.
        n = 0;
        while (!(g_row == 1 && g_col == 3) && n < 100) begin
            step();
            n++;
        end
        chk("pre_reset_locked", 32'(locked), 1);
        chk("pre_reset_err_cnt", 32'(err_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("async_reset");
        repeat (3) step();
        all_zero("held_reset");
        rst_n = 1'b1;
        wait_lock("rst_relock", 3, pulses);
        chk("rst_no_err_pulse", pulses, 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);

        // 300 mismatches while locked: count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            wait_lock("sat_relock", 0, pulses);
            dly_row = g_row;
            dly_on  = 1'b1;
            repeat (12) step();
            dly_on = 1'b0;
            chk("sat_err_cnt", 32'(err_cnt), (i + 1 > 255) ? 255 : i + 1);
        end
        chk("sat_final", 32'(err_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive end of the VGA link: takes the 640x480 sync and 3-bit RGB stream produced by the pattern generator / sync-porch path and recovers pixel column/row coordinates. Measures HSync/VSync timing against the expected frame geometry and runs a lock state machine. Emits an active-video qualifier, a frame-start strobe and error reporting. Used for on-chip loopback checking and as the front end of future capture blocks.

Parameters:
c_VIDEO_WIDTH, 3, bits per colour channel
c_TOTAL_COLS, 800, clocks per line
c_TOTAL_ROWS, 525, lines per frame
c_ACTIVE_COLS, 640, active pixels per line
c_ACTIVE_ROWS, 480, active lines per frame
c_H_SYNC_START, 658, column of first low HSync sample (active + front porch 18)
c_V_SYNC_START, 490, row of first low VSync sample (active + front porch 10), always at column 0
c_LOCK_FRAMES, 2, consecutive good VSync periods required to lock

Ports:
i_Clk  in  1  pixel clock (25 MHz)
i_Rst_L  in  1  reset, asynchronous, active-low
i_HSync  in  1  horizontal sync, active-low
i_VSync  in  1  vertical sync, active-low
i_Red_Video / i_Grn_Video / i_Blu_Video  in  3 each  pixel data
o_Col_Count  out  10  column of pixel on o_*_Video
o_Row_Count  out  10  row of pixel on o_*_Video
o_Red_Video / o_Grn_Video / o_Blu_Video  out  3 each  pixel data, zero outside active video
o_Active  out  1  o_Locked and col < c_ACTIVE_COLS and row < c_ACTIVE_ROWS
o_Frame_Start  out  1  one-cycle pulse with pixel (0,0) while locked
o_Locked  out  1  lock indicator
o_Sync_Err  out  1  one-cycle pulse on timing mismatch
o_Err_Count  out  8  saturating mismatch count

Behaviour:
- Clock and reset: single clock i_Clk. Reset is asynchronous and active-low (i_Rst_L).
- Reset values: all outputs 0, FSM = SEARCH. Internal sync registers reset to 1 (idle), so release never produces a false edge.
- Input pipeline: syncs and RGB pass through two register stages (s1, s2). Fixed pin-to-output latency is 2 cycles. Pixel data stays aligned with the reported coordinates.
- Edge detection:
  - H edge: s1 HSync = 0 and s2 HSync = 1.
  - V edge: same rule on VSync.
  - Both edges are evaluated on the same sample and may coincide.
- Column counter: increments each cycle and wraps c_TOTAL_COLS-1 -> 0.
  - Row increments on column wrap and wraps c_TOTAL_ROWS-1 -> 0.
  - On an H edge, the column for that sample is forced to c_H_SYNC_START.
  - On a V edge, the row is forced to c_V_SYNC_START and the column is forced to 0. The V force takes priority over the H force.
- Mismatch:
  - H-type: at an H edge, the predicted column ≠ c_H_SYNC_START.
  - V-type: at a V edge, the predicted (col, row) ≠ (0, c_V_SYNC_START).
  - Timeout: no H edge for 2*c_TOTAL_COLS cycles counts as a mismatch.
  - Simultaneous H and V mismatch counts once.
- FSM:
  - SEARCH: o_Locked = 0. An H edge has been seen and the first V edge arrives → TRACK, good = 0.
  - TRACK: each mismatch-free V edge increments good. When good reaches c_LOCK_FRAMES → LOCKED. Any mismatch → SEARCH; no o_Sync_Err pulse.
  - LOCKED: o_Locked = 1. Any mismatch → pulse o_Sync_Err, increment o_Err_Count (saturates at 255), → SEARCH.
  - In every state the counters still resynchronise to the edges.
- o_Frame_Start and o_Active are 0 whenever o_Locked = 0.
- Reset asserted mid-frame: immediate return to reset values. Relock requires the full SEARCH/TRACK sequence.

Decomposition:
- Shared package `vga_pkg`:
  - geometry constants: total/active cols and rows, porches, sync starts
  - state encoding SEARCH/TRACK/LOCKED
  - the generator uses the same constants
- One sub-module `vga_edge_sync`: two-stage register plus falling-edge detect, instantiated once per sync line.

Test Plan:
- Clean loopback from the generator/porch path, default parameters → o_Locked rises within 2 cycles after the 3rd VSync falling edge. Thereafter:
  - o_Frame_Start fires once per 420000 clocks;
  - o_Active is high for 640 clocks per line over 480 lines;
  - o_Col_Count = 658 on the first low-HSync pixel.
- Locked, then one HSync pulse delayed by 1 clock → o_Sync_Err pulses once, o_Err_Count = 1, o_Locked = 0. Relock occurs after 3 more clean VSync edges.
- Hold HSync high for 1600+ clocks while locked → timeout mismatch and o_Locked = 0. Restore HSync → relock.
- Random RGB input, locked → o_*_Video equals input delayed 2 clocks inside active video, and equals 0 at col 640–799 and row 480–524.
- Drop i_Rst_L mid-line while locked → all outputs 0 asynchronously, no o_Sync_Err pulse on release, o_Err_Count cleared.
- Inject 300 mismatches → o_Err_Count saturates at 255.
